uart_rx_fifo: RTL

Receive buffer sitting directly downstream of the UART receiver. Captures each byte the receiver reports with its single-cycle `done` pulse, stores it in a circular FIFO, and presents it to the consumer (bus interface / CPU) over a valid/ready handshake. Tracks overrun and framing-error status as sticky flags, so no receiver event is lost silently.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 29 ++
 rtl/uart_rx_fifo.sv | 126 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants for the receive path.
package uart_pkg;

  localparam int unsigned UART_BYTE_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  typedef logic [UART_BYTE_W-1:0] uart_byte_t;

  typedef struct packed {
    logic overrun;
    logic frameErr;
  } uart_rx_status_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART receive FIFO: synchronous write, asynchronous read.
// Contents are intentionally not reset.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int unsigned Depth = UART_FIFO_DEPTH,
  parameter int unsigned Width = UART_BYTE_W,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             i_wEn,
  input  logic [AddrW-1:0] i_wAddr,
  input  logic [Width-1:0] i_wData,
  input  logic [AddrW-1:0] i_rAddr,
  output logic [Width-1:0] o_rData
);

  logic [Width-1:0] r_mem [Depth];

  // Write port
  always_ff @(posedge clk) begin
    if (i_wEn) begin
      r_mem[i_wAddr] <= i_wData;
    end
  end

  assign o_rData = r_mem[i_rAddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive buffer behind the UART receiver: circular FIFO with first-word
// fall-through valid/ready output plus sticky overrun / framing-error flags.
// Optional macro UART_RX_FIFO_ERRCNT_EN adds a saturating errCount output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned Depth           = UART_FIFO_DEPTH,
  parameter int unsigned AlmostFullLevel = 12
) (
  input  logic                 clk,
  input  logic                 nReset,
  input  uart_byte_t           rxData,
  input  logic                 rxDone,
  input  logic                 rxErr,
  output uart_byte_t           outData,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [$clog2(Depth):0] count,
  output logic                 almostFull,
  output logic                 overrun,
  output logic                 frameErr,
  input  logic                 clearStatus
`ifdef UART_RX_FIFO_ERRCNT_EN
  ,
  output logic [7:0]           errCount
`endif
);

  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0] r_wPtr;
  logic [PtrW-1:0] r_rPtr;
  uart_rx_status_t r_status;
  uart_rx_status_t w_statusNext;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  // Occupancy decode; the pointer MSB separates full from empty
  assign w_empty = (r_wPtr == r_rPtr);
  assign w_full  = (r_wPtr[AddrW-1:0] == r_rPtr[AddrW-1:0]) &&
                   (r_wPtr[AddrW] != r_rPtr[AddrW]);

  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  assign w_pop  = !w_empty && outReady;
  assign w_push = rxDone && (!w_full || w_pop);
  assign w_drop = rxDone && w_full && !w_pop;

  // Read/write pointers, wrapping modulo 2*Depth
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_wPtr <= '0;
      r_rPtr <= '0;
    end else begin
      if (w_push) begin
        r_wPtr <= r_wPtr + PtrW'(1);
      end
      if (w_pop) begin
        r_rPtr <= r_rPtr + PtrW'(1);
      end
    end
  end

  uart_fifo_mem #(
    .Depth (Depth),
    .Width (UART_BYTE_W)
  ) u_mem (
    .clk     (clk),
    .i_wEn   (w_push),
    .i_wAddr (r_wPtr[AddrW-1:0]),
    .i_wData (rxData),
    .i_rAddr (r_rPtr[AddrW-1:0]),
    .o_rData (outData)
  );

  // Sticky status: clear first, then a same-cycle set event wins
  always_comb begin
    w_statusNext = r_status;
    if (clearStatus) begin
      w_statusNext = '0;
    end
    if (w_drop) begin
      w_statusNext.overrun = 1'b1;
    end
    if (rxErr) begin
      w_statusNext.frameErr = 1'b1;
    end
  end

  // Status register
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_status <= '0;
    end else begin
      r_status <= w_statusNext;
    end
  end

`ifdef UART_RX_FIFO_ERRCNT_EN
  logic [7:0] r_errCount;

  // Saturating rxErr counter; clear and a same-cycle error leave it at 1
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_errCount <= '0;
    end else if (clearStatus) begin
      r_errCount <= rxErr ? 8'd1 : 8'd0;
    end else if (rxErr && (r_errCount != 8'hFF)) begin
      r_errCount <= r_errCount + 8'd1;
    end
  end

  assign errCount = r_errCount;
`endif

  assign outValid   = !w_empty;
  assign count      = r_wPtr - r_rPtr;
  assign almostFull = (count >= PtrW'(AlmostFullLevel));
  assign overrun    = r_status.overrun;
  assign frameErr   = r_status.frameErr;

endmodule
